// File: rtl/spi_master.sv
// Single-chip-select SPI master: one DATA_WIDTH-bit full-duplex transfer per start pulse,
// MSB first, all four CPOL/CPHA modes, SCLK from an integer divider of clk.
module spi_master #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SPI_FREQ   = 5_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [DATA_WIDTH-1:0] data_send,
    input  logic                  spi_start,
    output logic                  sclk,
    output logic                  csn,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  spi_done,
    output logic [DATA_WIDTH-1:0] data_recv
);
    // state | meaning
    // IDLE  | csn high, sclk at CPOL, waiting for spi_start
    // XFER  | csn low, 2*DATA_WIDTH sclk toggles followed by one tail half-period
    // DONE  | single cycle: csn high, spi_done high, data_recv updated

    localparam int HALF_RAW = CLK_FREQ / (2 * SPI_FREQ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int EDGES    = 2 * DATA_WIDTH;
    localparam int EDGE_W   = $clog2(EDGES + 1);

    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(HALF - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);
    localparam logic [EDGE_W-1:0] EDGE_END  = EDGE_W'(EDGES);
    localparam logic              SCLK_IDLE = (CPOL != 0);
    localparam logic              SAMPLE_ON_LEAD = (CPHA == 0);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                state, state_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  tc, toggle, finish, start_acc, leading, last_trail;

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        toggle     = 1'b0;
        finish     = 1'b0;
        tc         = (div_cnt == '0);
        leading    = ~edge_cnt[0];
        last_trail = (edge_cnt == EDGE_LAST);
        case (state)
            IDLE: begin
                if (spi_start) begin
                    start_acc = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (tc) begin
                    if (edge_cnt == EDGE_END) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        toggle = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            sclk      <= SCLK_IDLE;
            csn       <= 1'b1;
            mosi      <= 1'b0;
            spi_done  <= 1'b0;
            data_recv <= '0;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
        end else begin
            spi_done <= 1'b0;
            if (start_acc) begin
                tx_sr    <= data_send;
                rx_sr    <= '0;
                csn      <= 1'b0;
                div_cnt  <= DIV_LOAD;
                edge_cnt <= '0;
                mosi     <= SAMPLE_ON_LEAD ? data_send[DATA_WIDTH-1] : 1'b0;
            end else if (state == XFER) begin
                if (tc) div_cnt <= DIV_LOAD;
                else    div_cnt <= div_cnt - 1'b1;
                if (toggle) begin
                    sclk     <= ~sclk;
                    edge_cnt <= edge_cnt + 1'b1;
                    if (leading == SAMPLE_ON_LEAD) begin
                        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                    end else if (!SAMPLE_ON_LEAD || !last_trail) begin
                        // CPHA=0 already presented the MSB when csn fell, so it
                        // drives the following bit; CPHA=1 drives the current MSB.
                        tx_sr <= tx_sr << 1;
                        mosi  <= SAMPLE_ON_LEAD ? tx_sr[DATA_WIDTH-2] : tx_sr[DATA_WIDTH-1];
                    end
                end
                if (finish) begin
                    csn       <= 1'b1;
                    spi_done  <= 1'b1;
                    data_recv <= rx_sr;
                    mosi      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a mode-0 and a mode-3 instance with a small
// behavioural slave and a cycle-level observer of the bus.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       arstn;
    logic [7:0] data_send0, data_send3, data_recv0, data_recv3;
    logic       spi_start0, spi_start3;
    logic       sclk0, sclk3, csn0, csn3, mosi0, mosi3, miso0, miso3;
    logic       spi_done0, spi_done3;

    int total = 0;
    int bad   = 0;

    logic [7:0] r_mosi;
    int r_csn_low, r_dones, r_rises, r_first_rise, r_spacing_bad, r_done_csn_bad;

    always #5 clk = ~clk;

    spi_master #(.CPOL(0), .CPHA(0)) dut0 (
        .clk(clk), .arstn(arstn), .data_send(data_send0), .spi_start(spi_start0),
        .sclk(sclk0), .csn(csn0), .mosi(mosi0), .miso(miso0),
        .spi_done(spi_done0), .data_recv(data_recv0)
    );

    spi_master #(.CPOL(1), .CPHA(1)) dut3 (
        .clk(clk), .arstn(arstn), .data_send(data_send3), .spi_start(spi_start3),
        .sclk(sclk3), .csn(csn3), .mosi(mosi3), .miso(miso3),
        .spi_done(spi_done3), .data_recv(data_recv3)
    );

    // Runs one transfer on the selected instance, acting as slave (miso updated on
    // falling sclk) and recording mosi at every rising sclk. Cycle index cyc counts
    // falling clk edges after the accepting rising edge.
    task automatic xfer(input int m, input logic [7:0] tx, input logic [7:0] pat,
                        input int busy_at, input logic [7:0] busy_data);
        logic ps, pc, s, c, d, mo;
        int   bitn, last_rise, tail;
        bit   fin;
        r_mosi = '0; r_csn_low = 0; r_dones = 0; r_rises = 0;
        r_first_rise = -1; r_spacing_bad = 0; r_done_csn_bad = 0;
        last_rise = -1; tail = -1; fin = 1'b0;
        @(negedge clk);
        if (m == 0) begin
            data_send0 = tx; spi_start0 = 1'b1; miso0 = pat[7]; bitn = 6;
            ps = sclk0;
        end else begin
            data_send3 = tx; spi_start3 = 1'b1; miso3 = 1'b0; bitn = 7;
            ps = sclk3;
        end
        pc = 1'b1;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            if (m == 0) begin
                spi_start0 = (cyc == busy_at);
                if (cyc == busy_at) data_send0 = busy_data;
                s = sclk0; c = csn0; d = spi_done0; mo = mosi0;
            end else begin
                spi_start3 = (cyc == busy_at);
                if (cyc == busy_at) data_send3 = busy_data;
                s = sclk3; c = csn3; d = spi_done3; mo = mosi3;
            end
            if (c == 1'b0) r_csn_low++;
            if (d) begin
                r_dones++;
                if (!(c == 1'b1 && pc == 1'b0)) r_done_csn_bad++;
                if (tail < 0) tail = cyc;
            end
            if (!ps && s) begin
                r_rises++;
                r_mosi = {r_mosi[6:0], mo};
                if (r_first_rise < 0) r_first_rise = cyc;
                else if (cyc - last_rise != 10) r_spacing_bad++;
                last_rise = cyc;
            end
            if (ps && !s && c == 1'b0 && bitn >= 0) begin
                if (m == 0) miso0 = pat[bitn];
                else        miso3 = pat[bitn];
                bitn--;
            end
            ps = s; pc = c;
            if (tail >= 0 && cyc >= tail + 4) fin = 1'b1;
        end
        spi_start0 = 1'b0; spi_start3 = 1'b0;
    endtask

    task automatic test_reset();
        int changes;
        arstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (sclk0 !== 1'b0) begin bad++; $display("FAIL reset_sclk0 got=%b want=0", sclk0); end
        total++; if (csn0 !== 1'b1) begin bad++; $display("FAIL reset_csn0 got=%b want=1", csn0); end
        total++; if (mosi0 !== 1'b0) begin bad++; $display("FAIL reset_mosi0 got=%b want=0", mosi0); end
        total++; if (spi_done0 !== 1'b0) begin bad++; $display("FAIL reset_done0 got=%b want=0", spi_done0); end
        total++; if (data_recv0 !== 8'h00) begin bad++; $display("FAIL reset_recv0 got=%h want=00", data_recv0); end
        total++; if (sclk3 !== 1'b1) begin bad++; $display("FAIL reset_sclk3 got=%b want=1", sclk3); end
        total++; if (csn3 !== 1'b1) begin bad++; $display("FAIL reset_csn3 got=%b want=1", csn3); end
        arstn = 1'b0;
        changes = 0;
        repeat (10) begin
            @(negedge clk);
            if (sclk0 !== 1'b0 || csn0 !== 1'b1 || mosi0 !== 1'b0 || spi_done0 !== 1'b0) changes++;
        end
        total++; if (changes !== 0) begin bad++; $display("FAIL idle_quiet got=%0d want=0", changes); end
    endtask

    task automatic test_mode0_tx();
        xfer(0, 8'hA5, 8'h00, -1, 8'h00);
        total++; if (r_mosi !== 8'hA5) begin bad++; $display("FAIL m0_mosi got=%h want=a5", r_mosi); end
        total++; if (r_csn_low !== 85) begin bad++; $display("FAIL m0_csn_low got=%0d want=85", r_csn_low); end
        total++; if (r_rises !== 8) begin bad++; $display("FAIL m0_rises got=%0d want=8", r_rises); end
        total++; if (r_first_rise !== 5) begin bad++; $display("FAIL m0_first_rise got=%0d want=5", r_first_rise); end
        total++; if (r_spacing_bad !== 0) begin bad++; $display("FAIL m0_spacing got=%0d want=0", r_spacing_bad); end
        total++; if (r_dones !== 1) begin bad++; $display("FAIL m0_dones got=%0d want=1", r_dones); end
        total++; if (r_done_csn_bad !== 0) begin bad++; $display("FAIL m0_done_at_csn_rise got=%0d want=0", r_done_csn_bad); end
    endtask

    task automatic test_mode0_rx();
        xfer(0, 8'h5A, 8'h3C, -1, 8'h00);
        total++; if (data_recv0 !== 8'h3C) begin bad++; $display("FAIL m0_recv got=%h want=3c", data_recv0); end
        total++; if (r_mosi !== 8'h5A) begin bad++; $display("FAIL m0_mosi_5a got=%h want=5a", r_mosi); end
        repeat (11) @(negedge clk);
        total++; if (data_recv0 !== 8'h3C) begin bad++; $display("FAIL m0_recv_hold got=%h want=3c", data_recv0); end
        xfer(0, 8'h9A, 8'hC3, -1, 8'h00);
        total++; if (r_mosi !== 8'h9A) begin bad++; $display("FAIL m0_mosi_9a got=%h want=9a", r_mosi); end
        total++; if (data_recv0 !== 8'hC3) begin bad++; $display("FAIL m0_recv2 got=%h want=c3", data_recv0); end
        total++; if (r_dones !== 1) begin bad++; $display("FAIL m0_dones2 got=%0d want=1", r_dones); end
    endtask

    task automatic test_mode3();
        total++; if (sclk3 !== 1'b1) begin bad++; $display("FAIL m3_idle_sclk got=%b want=1", sclk3); end
        xfer(3, 8'hA5, 8'h69, -1, 8'h00);
        total++; if (r_mosi !== 8'hA5) begin bad++; $display("FAIL m3_mosi got=%h want=a5", r_mosi); end
        total++; if (data_recv3 !== 8'h69) begin bad++; $display("FAIL m3_recv got=%h want=69", data_recv3); end
        total++; if (r_csn_low !== 85) begin bad++; $display("FAIL m3_csn_low got=%0d want=85", r_csn_low); end
        total++; if (r_first_rise !== 10) begin bad++; $display("FAIL m3_first_rise got=%0d want=10", r_first_rise); end
        total++; if (r_rises !== 8) begin bad++; $display("FAIL m3_rises got=%0d want=8", r_rises); end
        total++; if (r_dones !== 1) begin bad++; $display("FAIL m3_dones got=%0d want=1", r_dones); end
        total++; if (sclk3 !== 1'b1) begin bad++; $display("FAIL m3_end_sclk got=%b want=1", sclk3); end
    endtask

    task automatic test_busy();
        xfer(0, 8'hA5, 8'h81, 20, 8'h0F);
        total++; if (r_mosi !== 8'hA5) begin bad++; $display("FAIL busy_mosi got=%h want=a5", r_mosi); end
        total++; if (r_csn_low !== 85) begin bad++; $display("FAIL busy_csn_low got=%0d want=85", r_csn_low); end
        total++; if (r_dones !== 1) begin bad++; $display("FAIL busy_dones got=%0d want=1", r_dones); end
        total++; if (data_recv0 !== 8'h81) begin bad++; $display("FAIL busy_recv got=%h want=81", data_recv0); end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        data_send0 = 8'hF0; spi_start0 = 1'b1; miso0 = 1'b1;
        @(negedge clk);
        spi_start0 = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (spi_done0) dones++;
        end
        total++; if (csn0 !== 1'b0) begin bad++; $display("FAIL abort_active got=%b want=0", csn0); end
        arstn = 1'b1;
        #1;
        total++; if (csn0 !== 1'b1) begin bad++; $display("FAIL abort_csn got=%b want=1", csn0); end
        total++; if (sclk0 !== 1'b0) begin bad++; $display("FAIL abort_sclk got=%b want=0", sclk0); end
        repeat (3) begin
            @(negedge clk);
            if (spi_done0) dones++;
        end
        total++; if (data_recv0 !== 8'h00) begin bad++; $display("FAIL abort_recv got=%h want=00", data_recv0); end
        arstn = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (spi_done0) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        xfer(0, 8'h3C, 8'hA6, -1, 8'h00);
        total++; if (r_mosi !== 8'h3C) begin bad++; $display("FAIL post_abort_mosi got=%h want=3c", r_mosi); end
        total++; if (data_recv0 !== 8'hA6) begin bad++; $display("FAIL post_abort_recv got=%h want=a6", data_recv0); end
        total++; if (r_csn_low !== 85) begin bad++; $display("FAIL post_abort_csn_low got=%0d want=85", r_csn_low); end
        total++; if (r_dones !== 1) begin bad++; $display("FAIL post_abort_dones got=%0d want=1", r_dones); end
    endtask

    initial begin
        arstn = 1'b1;
        data_send0 = '0; data_send3 = '0;
        spi_start0 = 1'b0; spi_start3 = 1'b0;
        miso0 = 1'b0; miso3 = 1'b0;
        test_reset();
        test_mode0_tx();
        test_mode0_rx();
        test_mode3();
        test_busy();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-chip-select SPI bus master that serialises one DATA_WIDTH-bit word on mosi and captures one word from miso per transfer, MSB first.
- Supports all four CPOL/CPHA modes; SCLK is derived from the system clock by an integer divider.
- Sits between a local controller (one-cycle start pulse plus data word) and an external SPI slave; reports completion with a one-cycle done pulse.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SPI_FREQ, 5_000_000, target SCLK frequency in Hz.
- DATA_WIDTH, 8, bits per transfer.
- CPOL, 0, SCLK idle level (0 = low, 1 = high).
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- arstn  input  1  asynchronous, active-high reset (1 = reset, despite the suffix).
- data_send  input  DATA_WIDTH  word to transmit; sampled only on an accepted spi_start.
- spi_start  input  1  one-cycle start request.
- sclk  output  1  SPI serial clock.
- csn  output  1  active-low chip select.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in, MSB first.
- spi_done  output  1  one-cycle pulse at end of transfer.
- data_recv  output  DATA_WIDTH  last received word.

Behaviour:
- HALF = CLK_FREQ/(2*SPI_FREQ), integer division, clamped to a minimum of 1. With the defaults HALF = 5, so the SCLK period is 10 clk cycles.
- Reset values: sclk = CPOL, csn = 1, mosi = 0, spi_done = 0, data_recv = 0, FSM = IDLE, all counters and shift registers = 0. Reset mid-transfer aborts it immediately with no done pulse.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - sclk = CPOL, csn = 1.
  - On spi_start = 1: latch data_send into the TX shift register and clear the RX register. On the next edge csn = 0, go to XFER.
  - For CPHA = 0, mosi = data_send[MSB] in the same cycle csn falls.
- XFER:
  - A divider counts HALF clk cycles per half-period. On each terminal count, sclk toggles and the edge counter increments.
  - The first toggle occurs HALF cycles after csn falls. There are 2*DATA_WIDTH toggles in total.
  - Leading edge = odd toggle (1st, 3rd, ...); trailing edge = even toggle.
  - CPHA = 0: sample miso into RX LSB (shift left) on leading edges. Shift TX left and drive the next bit on mosi on trailing edges, except after the final trailing edge.
  - CPHA = 1: drive the next TX bit on mosi on leading edges (MSB on the 1st). Sample miso on trailing edges.
  - After the final toggle, sclk is back at CPOL. Wait HALF more cycles, then go to DONE.
- DONE (one cycle):
  - csn = 1, spi_done = 1, data_recv <= RX register, mosi = 0, return to IDLE.
  - csn is low for HALF*(2*DATA_WIDTH+1) clk cycles: 85 with the defaults.
- spi_start asserted outside IDLE (XFER or DONE) is ignored. A start in the cycle after DONE is accepted normally.
- data_recv holds its value until the next DONE.
- spi_done is never high for more than one cycle.
- data_send changes after acceptance do not affect the current transfer.

Test Plan:
- Reset: hold arstn = 1 for 3 cycles -> sclk = 0, csn = 1, mosi = 0, spi_done = 0, data_recv = 0. Nothing changes until spi_start.
- Mode 0, data_send = 8'hA5, one-cycle spi_start -> csn low for 85 cycles, 8 SCLK rising edges 10 cycles apart. mosi at each rising edge = 1,0,1,0,0,1,0,1. One spi_done pulse as csn rises.
- Mode 0 receive: slave changes miso on falling sclk with pattern 8'h3C -> data_recv = 8'h3C after spi_done. Then a second start 15 cycles after done with 8'h9A -> mosi sequence 1,0,0,1,1,0,1,0.
- CPOL = 1, CPHA = 1, data 8'hA5, slave updates miso on falling sclk -> sclk idles high. mosi changes on falling edges and is stable at the rising (sampling) edges with 1,0,1,0,0,1,0,1. data_recv equals the driven pattern.
- Busy: pulse spi_start again 20 cycles into a transfer with a different data_send -> ignored; the transmitted word and the 85-cycle csn window are unchanged.
- Abort: assert arstn mid-transfer -> csn = 1 and sclk = CPOL immediately, no spi_done, data_recv = 0. A following start performs a complete, correct transfer.
